rv_int_ctrl: RTL and testbench

Parametrised trap/interrupt controller for the single-cycle RISC-V core, owning the architectural PC register. It accepts N external interrupt lines plus the ecall, mret and illegal-instruction strobes from the decoder. It selects the next PC as one of: the normal datapath next-PC, a trap vector, or mepc on mret. It keeps machine-mode trap state (status, mask, mtvec, mepc, mcause), which software can read and write through a small CSR port.

---
 rtl/rv_int_ctrl_pkg.sv | 18 +
 rtl/rv_int_ctrl_irq_sync_edge.sv | 34 +++
 rtl/rv_int_ctrl.sv | 152 +++++++++++++++
 tb/tb_rv_int_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_int_ctrl_pkg.sv
// Shared constants for the trap/interrupt controller:
// cause codes, CSR addresses and mstatus bit positions.
package rv_int_ctrl_pkg;

    localparam logic [31:0] CAUSE_ILL      = 32'd2;
    localparam logic [31:0] CAUSE_ECALL    = 32'd11;
    localparam logic [31:0] IRQ_CAUSE_BASE = 32'd16;
    localparam logic [31:0] INT_FLAG       = 32'h8000_0000;

    localparam logic [1:0] CSR_MSTATUS = 2'd0;
    localparam logic [1:0] CSR_MIE     = 2'd1;
    localparam logic [1:0] CSR_MTVEC   = 2'd2;
    localparam logic [1:0] CSR_MEPC    = 2'd3;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/rv_int_ctrl_irq_sync_edge.sv
// Per-line irq synchroniser, rising-edge detect and pending latch.
// Ports: i_irq async level in, i_clr clears pending, o_pending latched request.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_irq,
    input  logic i_clr,
    output logic o_pending
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic                   r_pend;
    logic                   w_edge;

    assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign o_pending = r_pend;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_dly  <= r_sync[SYNC_STAGES-1];
            // A fresh edge beats a same-cycle clear.
            r_pend <= w_edge | (r_pend & ~i_clr);
        end
    end

endmodule

// File: rtl/rv_int_ctrl.sv
// Machine-mode trap/interrupt controller owning the core PC.
// Ports: irq/ecall/mret/ill_instr events, pc_next, CSR port; pc, mepc, mcause, in_trap, irq_pending out.
module rv_int_ctrl
    import rv_int_ctrl_pkg::*;
#(
    parameter int          N_IRQ       = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_000C,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             ecall,
    input  logic             mret,
    input  logic             ill_instr,
    input  logic [31:0]      pc_next,
    input  logic             csr_we,
    input  logic [1:0]       csr_addr,
    input  logic [31:0]      csr_wdata,
    output logic [31:0]      csr_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      mepc,
    output logic [31:0]      mcause,
    output logic             in_trap,
    output logic [N_IRQ-1:0] irq_pending
);

    logic [31:0]      r_pc;
    logic [31:0]      r_mepc;
    logic [31:0]      r_mcause;
    logic [31:0]      r_mtvec;
    logic [N_IRQ-1:0] r_mask;
    logic             r_mie;
    logic             r_mpie;
    logic             r_in_trap;

    logic [N_IRQ-1:0] w_pend;
    logic [N_IRQ-1:0] w_hit;
    logic [N_IRQ-1:0] w_clr;
    logic [3:0]       w_sel;
    logic             w_exc;
    logic             w_take;
    logic [31:0]      w_irq_code;
    logic [31:0]      w_base;
    logic [31:0]      w_irq_vec;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_irq    (irq[g]),
            .i_clr    (w_clr[g]),
            .o_pending(w_pend[g])
        );
    end

    assign w_hit  = w_pend & r_mask;
    assign w_exc  = ill_instr | ecall;
    // Exceptions and mret outrank interrupts for this cycle.
    assign w_take = r_mie & (|w_hit) & ~w_exc & ~mret;

    // Lowest set index has highest priority.
    always_comb begin
        w_sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_hit[i]) w_sel = 4'(i);
        end
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_clr[i] = w_take && (w_sel == 4'(i));
        end
    end

    assign w_irq_code = IRQ_CAUSE_BASE + {28'd0, w_sel};
    assign w_base     = {r_mtvec[31:2], 2'b00};
    assign w_irq_vec  = r_mtvec[0] ? w_base + (w_irq_code << 2)
                                   : w_base;

    always_comb begin
        csr_rdata = '0;
        unique case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = r_mie;
                csr_rdata[MSTATUS_MPIE] = r_mpie;
            end
            CSR_MIE:   csr_rdata = 32'(r_mask);
            CSR_MTVEC: csr_rdata = r_mtvec;
            CSR_MEPC:  csr_rdata = r_mepc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_mepc    <= '0;
            r_mcause  <= '0;
            r_mtvec   <= MTVEC_RESET;
            r_mask    <= '1;
            r_mie     <= 1'b1;
            r_mpie    <= 1'b0;
            r_in_trap <= 1'b0;
        end else begin
            // CSR writes first; trap/mret updates below override them.
            if (csr_we) begin
                unique case (csr_addr)
                    CSR_MSTATUS: begin
                        r_mie  <= csr_wdata[MSTATUS_MIE];
                        r_mpie <= csr_wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE:   r_mask  <= csr_wdata[N_IRQ-1:0];
                    CSR_MTVEC: r_mtvec <= csr_wdata;
                    CSR_MEPC:  r_mepc  <= {csr_wdata[31:2], 2'b00};
                endcase
            end
            if (w_exc) begin
                r_mcause  <= ill_instr ? CAUSE_ILL : CAUSE_ECALL;
                r_mepc    <= r_pc;
                r_pc      <= w_base;
                r_mpie    <= r_mie;
                r_mie     <= 1'b0;
                r_in_trap <= 1'b1;
            end else if (mret) begin
                r_pc      <= r_mepc;
                r_mie     <= r_mpie;
                r_mpie    <= 1'b1;
                r_in_trap <= 1'b0;
            end else if (w_take) begin
                r_mcause  <= INT_FLAG | w_irq_code;
                r_mepc    <= pc_next;
                r_pc      <= w_irq_vec;
                r_mpie    <= r_mie;
                r_mie     <= 1'b0;
                r_in_trap <= 1'b1;
            end else begin
                r_pc <= pc_next;
            end
        end
    end

    assign pc          = r_pc;
    assign mepc        = r_mepc;
    assign mcause      = r_mcause;
    assign in_trap     = r_in_trap;
    assign irq_pending = w_pend;

endmodule

// File: tb/tb_rv_int_ctrl.sv
// Directed scoreboard bench for rv_int_ctrl.
// Expectations are queued with each stimulus step and checked after the edge.
module tb_rv_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic        ecall;
    logic        mret;
    logic        ill_instr;
    logic [31:0] pc_next;
    logic        csr_we;
    logic [1:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [31:0] pc;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic        in_trap;
    logic [3:0]  irq_pending;

    logic        use_ovr;
    logic [31:0] pc_ovr;

    int n_cmp;
    int n_bad;

    string       q_tag[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];

    localparam int S_PC   = 0;
    localparam int S_MEPC = 1;
    localparam int S_CAUS = 2;
    localparam int S_TRAP = 3;
    localparam int S_PEND = 4;
    localparam int S_RD   = 5;

    assign pc_next = use_ovr ? pc_ovr : pc + 32'd4;

    rv_int_ctrl #(
        .N_IRQ      (4),
        .RESET_PC   (32'h0000_0000),
        .MTVEC_RESET(32'h0000_000C),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .ecall      (ecall),
        .mret       (mret),
        .ill_instr  (ill_instr),
        .pc_next    (pc_next),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .pc         (pc),
        .mepc       (mepc),
        .mcause     (mcause),
        .in_trap    (in_trap),
        .irq_pending(irq_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_v(input string tag, input int sel,
                            input logic [31:0] v);
        q_tag.push_back(tag);
        q_sel.push_back(sel);
        q_exp.push_back(v);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_PC:    return pc;
            S_MEPC:  return mepc;
            S_CAUS:  return mcause;
            S_TRAP:  return {31'd0, in_trap};
            S_PEND:  return {28'd0, irq_pending};
            default: return csr_rdata;
        endcase
    endfunction

    task automatic drain();
        string       tag;
        int          sel;
        logic [31:0] ex;
        logic [31:0] ob;
        while (q_exp.size() > 0) begin
            tag = q_tag.pop_front();
            sel = q_sel.pop_front();
            ex  = q_exp.pop_front();
            ob  = observe(sel);
            n_cmp++;
            assert (ob === ex) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", tag, ob, ex);
            end
        end
    endtask

    // Advance one edge, then check everything queued for it.
    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        irq       = '0;
        ecall     = 1'b0;
        mret      = 1'b0;
        ill_instr = 1'b0;
        csr_we    = 1'b0;
        csr_addr  = 2'd0;
        csr_wdata = '0;
        use_ovr   = 1'b0;
        pc_ovr    = '0;

        // Reset state
        #11;
        expect_v("rst_pc", S_PC, 32'h0);
        expect_v("rst_mepc", S_MEPC, 32'h0);
        expect_v("rst_mcause", S_CAUS, 32'h0);
        expect_v("rst_trap", S_TRAP, 32'h0);
        expect_v("rst_pend", S_PEND, 32'h0);
        expect_v("rst_mstatus", S_RD, 32'h8);
        #1;
        drain();
        csr_addr = 2'd2;
        expect_v("rst_mtvec", S_RD, 32'hC);
        #1;
        drain();
        csr_addr = 2'd1;
        expect_v("rst_mask", S_RD, 32'hF);
        #1;
        drain();
        rst = 1'b0;
        csr_addr = 2'd0;

        // Sequential fetch 0,4,8,C,10
        expect_v("seq_pc4", S_PC, 32'h4);
        step();
        expect_v("seq_pc8", S_PC, 32'h8);
        expect_v("seq_mcause", S_CAUS, 32'h0);
        expect_v("seq_trap", S_TRAP, 32'h0);
        step();
        step();
        expect_v("seq_pc10", S_PC, 32'h10);
        step();

        // ecall at 0x10, then mret
        ecall = 1'b1;
        expect_v("ecall_pc", S_PC, 32'hC);
        expect_v("ecall_mepc", S_MEPC, 32'h10);
        expect_v("ecall_cause", S_CAUS, 32'd11);
        expect_v("ecall_trap", S_TRAP, 32'h1);
        expect_v("ecall_mstat", S_RD, 32'h80);
        step();
        ecall = 1'b0;
        mret  = 1'b1;
        expect_v("mret_pc", S_PC, 32'h10);
        expect_v("mret_mstat", S_RD, 32'h88);
        expect_v("mret_trap", S_TRAP, 32'h0);
        step();
        mret = 1'b0;

        // irq[2] with pc_next held at 0x24
        use_ovr = 1'b1;
        pc_ovr  = 32'h24;
        irq[2]  = 1'b1;
        expect_v("irq2_e0_pend", S_PEND, 32'h0);
        step();
        expect_v("irq2_e1_pend", S_PEND, 32'h0);
        expect_v("irq2_e1_trap", S_TRAP, 32'h0);
        step();
        expect_v("irq2_e2_pend", S_PEND, 32'h4);
        expect_v("irq2_e2_pc", S_PC, 32'h24);
        step();
        expect_v("irq2_pc", S_PC, 32'hC);
        expect_v("irq2_cause", S_CAUS, 32'h8000_0012);
        expect_v("irq2_mepc", S_MEPC, 32'h24);
        expect_v("irq2_pend", S_PEND, 32'h0);
        expect_v("irq2_trap", S_TRAP, 32'h1);
        step();
        irq[2]  = 1'b0;
        use_ovr = 1'b0;
        mret    = 1'b1;
        expect_v("irq2_ret_pc", S_PC, 32'h24);
        step();
        mret = 1'b0;

        // Vectored mode, irq[1] and irq[3] together
        csr_we    = 1'b1;
        csr_addr  = 2'd2;
        csr_wdata = 32'h101;
        expect_v("mtvec_rd", S_RD, 32'h101);
        expect_v("mtvec_pc", S_PC, 32'h28);
        step();
        csr_we = 1'b0;
        irq    = 4'b1010;
        step();
        step();
        expect_v("vec_pend", S_PEND, 32'hA);
        step();
        expect_v("vec_pc", S_PC, 32'h144);
        expect_v("vec_cause", S_CAUS, 32'h8000_0011);
        expect_v("vec_mepc", S_MEPC, 32'h38);
        expect_v("vec_pend3", S_PEND, 32'h8);
        step();
        irq  = 4'b0000;
        mret = 1'b1;
        expect_v("vec_ret_pc", S_PC, 32'h38);
        step();
        mret = 1'b0;
        expect_v("vec3_pc", S_PC, 32'h14C);
        expect_v("vec3_cause", S_CAUS, 32'h8000_0013);
        expect_v("vec3_mepc", S_MEPC, 32'h3C);
        expect_v("vec3_pend", S_PEND, 32'h0);
        step();
        mret = 1'b1;
        expect_v("vec3_ret_pc", S_PC, 32'h3C);
        step();
        mret = 1'b0;

        // Masked irq[0] stays pending, then unmask
        csr_we    = 1'b1;
        csr_addr  = 2'd1;
        csr_wdata = 32'hFFFF_FFEE;
        expect_v("mask_rd", S_RD, 32'hE);
        step();
        csr_we = 1'b0;
        irq[0] = 1'b1;
        step();
        step();
        step();
        expect_v("mask_pend", S_PEND, 32'h1);
        expect_v("mask_trap", S_TRAP, 32'h0);
        expect_v("mask_pc", S_PC, 32'h50);
        step();
        csr_we    = 1'b1;
        csr_wdata = 32'hF;
        expect_v("unmask_pc", S_PC, 32'h54);
        expect_v("unmask_trap", S_TRAP, 32'h0);
        step();
        csr_we = 1'b0;
        expect_v("irq0_pc", S_PC, 32'h140);
        expect_v("irq0_cause", S_CAUS, 32'h8000_0010);
        expect_v("irq0_mepc", S_MEPC, 32'h58);
        expect_v("irq0_pend", S_PEND, 32'h0);
        step();
        irq[0] = 1'b0;

        // ill_instr beats mret inside a handler
        ill_instr = 1'b1;
        mret      = 1'b1;
        csr_addr  = 2'd0;
        expect_v("ill_pc", S_PC, 32'h100);
        expect_v("ill_cause", S_CAUS, 32'd2);
        expect_v("ill_mepc", S_MEPC, 32'h140);
        expect_v("ill_trap", S_TRAP, 32'h1);
        expect_v("ill_mstat", S_RD, 32'h0);
        step();
        ill_instr = 1'b0;
        mret      = 1'b0;

        // mepc write drops low bits; mret returns there
        csr_we    = 1'b1;
        csr_addr  = 2'd3;
        csr_wdata = 32'h203;
        expect_v("mepc_wr", S_RD, 32'h200);
        step();
        csr_we = 1'b0;
        mret   = 1'b1;
        expect_v("mepc_ret", S_PC, 32'h200);
        step();
        mret = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
